data_mem_responder: RTL and testbench

//  Data-memory responder for the RV32I core: the target side of the MemRead/MemWrite

---
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind MemRead/MemWrite with byte/half lane handling and load extension.
// Latency: done pulses READ_LATENCY+1 cycles after a request first appears in IDLE; rdata is registered.
// Backpressure: stall holds the core from accept until DONE; requests seen in BUSY/DONE are ignored.
module data_mem_responder #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic                  lat_rd, lat_wr;
    logic [2:0]            lat_f3;
    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic                  err_q;

    logic [31:0] mem [0:DEPTH-1];

    // Upper address bits alias; they are deliberately unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    logic                  accept, go_done;
    logic                  op_rd, op_wr;
    logic [2:0]            op_f3;
    logic [ADDR_WIDTH+1:0] op_addr;
    logic [31:0]           op_wdata;
    logic                  size_bad, f3_bad, op_err;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           rd_word, wr_word, shifted, ld_val;

    assign accept = (state == S_IDLE) && (MemRead || MemWrite);

    // With zero latency the commit happens on the accept edge, so use live inputs in IDLE.
    assign op_rd    = (state == S_IDLE) ? MemRead  : lat_rd;
    assign op_wr    = (state == S_IDLE) ? MemWrite : lat_wr;
    assign op_f3    = (state == S_IDLE) ? funct3   : lat_f3;
    assign op_addr  = (state == S_IDLE) ? addr[ADDR_WIDTH+1:0] : lat_addr;
    assign op_wdata = (state == S_IDLE) ? wdata    : lat_wdata;

    // FSM state register, request capture and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_rd    <= 1'b0;
            lat_wr    <= 1'b0;
            lat_f3    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_rd    <= MemRead;
                lat_wr    <= MemWrite;
                lat_f3    <= funct3;
                lat_addr  <= addr[ADDR_WIDTH+1:0];
                lat_wdata <= wdata;
                cnt       <= CNT_LOAD;
            end else if (state == S_BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Next-state and stall decode.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        go_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    stall = 1'b1;
                    if (READ_LATENCY == 0) begin
                        state_nxt = S_DONE;
                        go_done   = 1'b1;
                    end else begin
                        state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    state_nxt = S_DONE;
                    go_done   = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Access legality: size alignment and funct3 encoding per access kind.
    always_comb begin
        size_bad = 1'b0;
        case (op_f3[1:0])
            2'b01:   size_bad = op_addr[0];
            2'b10:   size_bad = (op_addr[1:0] != 2'b00);
            default: size_bad = 1'b0;
        endcase
        if (op_rd)
            f3_bad = (op_f3 == 3'b011) || (op_f3[2] && op_f3[1]);
        else
            f3_bad = op_f3[2] || (op_f3[1] && op_f3[0]);
        op_err = (op_rd && op_wr) || size_bad || f3_bad;
    end

    assign idx     = op_addr[ADDR_WIDTH+1:2];
    assign rd_word = mem[idx];
    assign shifted = rd_word >> {op_addr[1:0], 3'b000};

    // Store lane merge and load extraction/extension.
    always_comb begin
        wr_word = rd_word;
        case (op_f3[1:0])
            2'b00:   wr_word[op_addr[1:0]*8 +: 8] = op_wdata[7:0];
            2'b01:   wr_word[op_addr[1]*16 +: 16] = op_wdata[15:0];
            default: wr_word = op_wdata;
        endcase
        case (op_f3)
            3'b000:  ld_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_val = {24'b0, shifted[7:0]};
            3'b101:  ld_val = {16'b0, shifted[15:0]};
            default: ld_val = shifted;
        endcase
    end

    // RAM commit on the edge entering DONE; never while reset is asserted.
    always_ff @(posedge clk) begin
        if (go_done && rst_n && op_wr && !op_err)
            mem[idx] <= wr_word;
    end

    // Load result and error flag, both captured at the commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
            err_q <= 1'b0;
        end else if (go_done) begin
            err_q <= op_err;
            if (op_rd)
                rdata <= op_err ? 32'h0 : ld_val;
        end
    end

    assign done = (state == S_DONE);
    assign err  = done && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (READ_LATENCY=2, ADDR_WIDTH=10).
// Latency: checks stall width and done timing on every access.
// Backpressure: requests are held until done, including back-to-back held through DONE.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall, done, err;

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_ops = 0, done_cnt = 0, stray_err = 0;
    logic [31:0] mdl_rdata = 32'h0;
    logic [32:0] sb_q[$];

    data_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata), .stall(stall), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!done && err) stray_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one access at a negedge, wait for done, pop and compare the scoreboard entry.
    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic e_err, input logic [31:0] e_val,
                      input logic keep, input string tag);
        logic [31:0] exp_r;
        logic [32:0] ent;
        int stalls;
        bit got;
        exp_r = rd ? (e_err ? 32'h0 : e_val) : mdl_rdata;
        mdl_rdata = exp_r;
        sb_q.push_back({e_err, exp_r});
        n_ops++;
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; wdata = wd;
        #1;
        if (done) @(negedge clk);
        stalls = 0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (done) got = 1;
            else begin
                if (stall) stalls++;
                @(negedge clk);
            end
        end
        if (!keep) begin
            MemRead = 1'b0;
            MemWrite = 1'b0;
        end
        ent = sb_q.pop_front();
        if (!got) chk({tag, ":timeout"}, 32'd0, 32'd1);
        chk({tag, ":err"}, {31'b0, err}, {31'b0, ent[32]});
        chk({tag, ":rdata"}, rdata, ent[31:0]);
        chk({tag, ":stall_cycles"}, stalls, 32'd3);
        if (!keep) @(negedge clk);
    endtask

    initial begin
        int dc;
        repeat (2) @(negedge clk);
        chk("reset:rdata", rdata, 32'h0);
        chk("reset:done", {31'b0, done}, 32'h0);
        chk("reset:err", {31'b0, err}, 32'h0);
        chk("reset:stall", {31'b0, stall}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store/load
        op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0, "sw10");
        op(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 0, "lw10");
        // Byte stores and loads
        op(0, 1, 3'b000, 32'h12, 32'h000000AD, 0, 0, 0, "sb12");
        op(0, 1, 3'b000, 32'h13, 32'hFFFFFF5A, 0, 0, 0, "sb13");
        op(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h5AADBEEF, 0, "lw10b");
        op(1, 0, 3'b000, 32'h12, 32'h0, 0, 32'hFFFFFFAD, 0, "lb12");
        op(1, 0, 3'b100, 32'h12, 32'h0, 0, 32'h000000AD, 0, "lbu12");
        op(1, 0, 3'b000, 32'h13, 32'h0, 0, 32'h0000005A, 0, "lb13");
        // Half loads (0x5AAD has bit 15 clear) and half store
        op(1, 0, 3'b001, 32'h12, 32'h0, 0, 32'h00005AAD, 0, "lh12");
        op(1, 0, 3'b101, 32'h12, 32'h0, 0, 32'h00005AAD, 0, "lhu12");
        op(0, 1, 3'b001, 32'h10, 32'hFFFF1234, 0, 0, 0, "sh10");
        op(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h5AAD1234, 0, "lw10c");
        op(1, 0, 3'b001, 32'h10, 32'h0, 0, 32'h00001234, 0, "lh10");
        // Rejected accesses
        op(0, 1, 3'b001, 32'h11, 32'hFFFFFFFF, 1, 0, 0, "sh11_err");
        op(1, 0, 3'b010, 32'h0E, 32'h0, 1, 0, 0, "lw0e_err");
        op(1, 0, 3'b011, 32'h10, 32'h0, 1, 0, 0, "ld011_err");
        op(0, 1, 3'b100, 32'h10, 32'h0, 1, 0, 0, "st100_err");
        op(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h5AAD1234, 0, "lw10d");
        op(1, 1, 3'b010, 32'h10, 32'h0, 1, 0, 0, "rw_err");
        op(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h5AAD1234, 0, "lw10e");
        op(1, 0, 3'b010, 32'h1010, 32'h0, 0, 32'h5AAD1234, 0, "lw_alias");

        // Reset during BUSY discards the pending store
        op(0, 1, 3'b010, 32'h20, 32'h0, 0, 0, 0, "sw20_0");
        dc = done_cnt;
        MemWrite = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h11111111;
        @(negedge clk);
        chk("abort:stall_busy", {31'b0, stall}, 32'h1);
        rst_n = 1'b0;
        MemWrite = 1'b0;
        #1;
        chk("abort:stall", {31'b0, stall}, 32'h0);
        chk("abort:done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mdl_rdata = 32'h0;
        repeat (4) @(negedge clk);
        chk("abort:no_done", done_cnt, dc);
        chk("abort:rdata", rdata, 32'h0);
        op(1, 0, 3'b010, 32'h20, 32'h0, 0, 32'h00000000, 0, "lw20");

        // Back-to-back requests held through DONE
        op(0, 1, 3'b010, 32'h24, 32'h00000077, 0, 0, 1, "b2b_sw");
        op(1, 0, 3'b000, 32'h24, 32'h0, 0, 32'h00000077, 1, "b2b_lb");
        op(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h5AAD1234, 0, "b2b_lw");

        repeat (4) @(negedge clk);
        chk("done_count", done_cnt, n_ops);
        chk("stray_err", stray_err, 32'h0);
        chk("sb_empty", sb_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
